// File: rtl/mont_exp_sequencer.sv
// Montgomery exponentiation sequencer: MSB-first square-and-multiply driving an external multiplier.
// Optional MONT_EXP_FINAL_CONV_EN adds a final Mont(A,1) step so the result leaves the Montgomery domain.
module mont_exp_sequencer #(
  parameter int WIDTH  = 1024,
  parameter int ELEN_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_elen,
  input  logic [WIDTH-1:0]  in_m,
  output logic              mult_start,
  output logic [WIDTH-1:0]  mult_a,
  output logic [WIDTH-1:0]  mult_b,
  output logic [WIDTH-1:0]  mult_m,
  input  logic [WIDTH-1:0]  mult_result,
  input  logic              mult_done,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQR  = 3'd1,
    MUL  = 3'd2,
`ifdef MONT_EXP_FINAL_CONV_EN
    CONV = 3'd3,
`endif
    FIN  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] m_q;
  logic [IDX_W-1:0] idx;
  // High in the first cycle of each multiply state: issues the pulse and masks mult_done.
  logic             issue;

  logic [31:0]      elen_ext;
  logic [31:0]      elen_clamped;
  logic [IDX_W-1:0] idx_init;
  logic             in_mult_state;
  logic             op_done;
  logic             cur_bit;
  logic             last_bit;

  assign elen_ext     = 32'(in_elen);
  assign elen_clamped = (elen_ext > 32'(WIDTH)) ? 32'(WIDTH) : elen_ext;
  assign idx_init     = IDX_W'(elen_clamped - 32'd1);
  assign cur_bit      = e_q[idx];
  assign last_bit     = (idx == '0);

`ifdef MONT_EXP_FINAL_CONV_EN
  assign in_mult_state = (state == SQR) || (state == MUL) || (state == CONV);
`else
  assign in_mult_state = (state == SQR) || (state == MUL);
`endif
  assign op_done = in_mult_state && !issue && mult_done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_t exit_state;
`ifdef MONT_EXP_FINAL_CONV_EN
    exit_state = CONV;
`else
    exit_state = FIN;
`endif
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (elen_clamped == 32'd0) ? FIN : SQR;
        end
      end
      SQR: begin
        if (op_done) begin
          if (cur_bit) begin
            state_next = MUL;
          end else if (!last_bit) begin
            state_next = SQR;
          end else begin
            state_next = exit_state;
          end
        end
      end
      MUL: begin
        if (op_done) begin
          state_next = last_bit ? exit_state : SQR;
        end
      end
`ifdef MONT_EXP_FINAL_CONV_EN
      CONV: begin
        if (op_done) begin
          state_next = FIN;
        end
      end
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc    <= '0;
      x_q    <= '0;
      e_q    <= '0;
      m_q    <= '0;
      idx    <= '0;
      issue  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        result <= acc;
      end
      if (state == IDLE) begin
        if (start) begin
          x_q   <= in_x;
          e_q   <= in_e;
          m_q   <= in_m;
          acc   <= in_r;
          idx   <= idx_init;
          issue <= 1'b1;
        end
      end else if (in_mult_state) begin
        if (issue) begin
          issue <= 1'b0;
        end else if (mult_done) begin
          acc   <= mult_result;
          issue <= 1'b1;
          // The bit index advances once the square (and its optional multiply) for this bit is finished.
          if (((state == MUL) || ((state == SQR) && !cur_bit)) && !last_bit) begin
            idx <= idx - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    mult_start = in_mult_state && issue;
    mult_a     = acc;
    mult_b     = acc;
    mult_m     = m_q;
    busy       = (state != IDLE) || done;
    if (state == MUL) begin
      mult_b = x_q;
    end
`ifdef MONT_EXP_FINAL_CONV_EN
    if (state == CONV) begin
      mult_b = ONE;
    end
`endif
  end

endmodule

// File: tb/tb_mont_exp_sequencer.sv
// Bench for mont_exp_sequencer: a modular-multiply responder plus a right-to-left exponentiation reference.
module tb_mont_exp_sequencer;

  localparam int WIDTH  = 1024;
  localparam int ELEN_W = 11;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`ifdef MONT_EXP_FINAL_CONV_EN
  localparam int N_CONV = 1;
`else
  localparam int N_CONV = 0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  in_x = '0;
  logic [WIDTH-1:0]  in_r = '0;
  logic [WIDTH-1:0]  in_e = '0;
  logic [ELEN_W-1:0] in_elen = '0;
  logic [WIDTH-1:0]  in_m = '0;
  logic              mult_start;
  logic [WIDTH-1:0]  mult_a;
  logic [WIDTH-1:0]  mult_b;
  logic [WIDTH-1:0]  mult_m;
  logic [WIDTH-1:0]  mult_result = '0;
  logic              mult_done = 1'b0;
  logic [WIDTH-1:0]  result;
  logic              done;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mont_exp_sequencer #(.WIDTH(WIDTH), .ELEN_W(ELEN_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_elen(in_elen), .in_m(in_m),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b), .mult_m(mult_m),
    .mult_result(mult_result), .mult_done(mult_done),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] modmul(input logic [WIDTH-1:0] a, b, m);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    p = p % {{WIDTH{1'b0}}, m};
    return p[WIDTH-1:0];
  endfunction

  // Reference: A_final = r^(2^k) * x^(e mod 2^k), x power taken right-to-left.
  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] r, x, e, m, input int n);
    int k;
    logic [WIDTH-1:0] p, q, b;
    k = (n > WIDTH) ? WIDTH : n;
    if (k == 0) return r;
    p = r;
    for (int i = 0; i < k; i++) p = modmul(p, p, m);
    q = ONE;
    b = x;
    for (int i = 0; i < k; i++) begin
      if (e[i]) q = modmul(q, b, m);
      b = modmul(b, b, m);
    end
    return modmul(p, q, m);
  endfunction

  function automatic int popcnt(input logic [WIDTH-1:0] e, input int n);
    int k, c;
    k = (n > WIDTH) ? WIDTH : n;
    c = 0;
    for (int i = 0; i < k; i++) c += int'(e[i]);
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] rand_w();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] rand_mod();
    logic [WIDTH-1:0] v;
    v = rand_w();
    v[WIDTH-1] = 1'b1;
    v[0] = 1'b1;
    return v;
  endfunction

  // Multiplier responder: accumulates statistics only; tests compare them.
  int               resp_lat = 1;
  bit               resp_pend = 0;
  int               resp_cnt = 0;
  logic [WIDTH-1:0] cap_a, cap_b, cap_m;
  int               last_done_cyc = -100;
  int               run_t0 = -100;
  int               tot_s = 0, tot_m = 0, tot_c = 0;
  int               stab_viol = 0, gap_viol = 0;
  string            seq_all = "";
  int               start_q[$];
  byte              cur_cls = 8'd0;

  always @(negedge clk) begin
    if (mult_done) mult_done = 1'b0;
    if (resp_pend) begin
      if (mult_start !== 1'b0 || mult_a !== cap_a || mult_b !== cap_b || mult_m !== cap_m) stab_viol++;
      resp_cnt--;
      if (resp_cnt <= 0) begin
        mult_result = modmul(cap_a, cap_b, cap_m);
        mult_done = 1'b1;
        resp_pend = 0;
        last_done_cyc = cyc;
      end
    end else if (mult_start === 1'b1) begin
      if (last_done_cyc > run_t0) begin
        if (cyc != last_done_cyc + 1) gap_viol++;
      end else if (cyc != run_t0 + 1) begin
        gap_viol++;
      end
      start_q.push_back(cyc);
      cap_a = mult_a;
      cap_b = mult_b;
      cap_m = mult_m;
      if (mult_a == mult_b) begin
        tot_s++; seq_all = {seq_all, "S"}; cur_cls = "S";
      end else if (mult_b == ONE) begin
        tot_c++; seq_all = {seq_all, "C"}; cur_cls = "C";
      end else begin
        tot_m++; seq_all = {seq_all, "M"}; cur_cls = "M";
      end
      resp_pend = 1;
      resp_cnt = resp_lat;
    end
  end

  logic [WIDTH-1:0] run_res;
  int    run_done_cyc, run_ns, run_nm, run_nc, run_first, run_stab, run_gap;
  bit    run_tmo, run_busy_at_done;
  string run_seq;

  task automatic do_run(input logic [WIDTH-1:0] x, r, e, m, input int n, input int lat);
    int s0, m0, c0, l0, q0, sv0, gv0, budget;
    @(posedge clk); #1;
    resp_lat = lat;
    s0 = tot_s; m0 = tot_m; c0 = tot_c; l0 = seq_all.len(); q0 = start_q.size();
    sv0 = stab_viol; gv0 = gap_viol;
    run_t0 = cyc;
    in_x = x; in_r = r; in_e = e; in_m = m; in_elen = ELEN_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = ((n > WIDTH) ? WIDTH : n) * 2 * (lat + 3) + 40;
    run_tmo = 1;
    run_res = '0;
    run_busy_at_done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        run_tmo = 0; run_done_cyc = cyc; run_res = result; run_busy_at_done = busy;
        break;
      end
    end
    run_ns = tot_s - s0; run_nm = tot_m - m0; run_nc = tot_c - c0;
    run_stab = stab_viol - sv0; run_gap = gap_viol - gv0;
    run_seq = (seq_all.len() > l0) ? seq_all.substr(l0, seq_all.len() - 1) : "";
    run_first = (start_q.size() > q0) ? start_q[q0] : -1;
    checks++;
    if (run_tmo) begin
      errors++;
      $display("FAIL run_timeout: done not seen within %0d cycles (required done pulse)", budget);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mult_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b mult_start=%b, required 0 0 0", busy, done, mult_start);
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h, required 0", result[63:0]);
    end
    checks++;
    if (mult_a !== '0 || mult_m !== '0) begin
      errors++;
      $display("FAIL reset_operands: a=%h m=%h, required 0", mult_a[63:0], mult_m[63:0]);
    end
    #1 resetn = 1'b1;
  endtask

  task automatic test_elen_zero;
    logic [WIDTH-1:0] r;
    r = rand_w();
    do_run(rand_w(), r, rand_w(), rand_mod(), 0, 2);
    checks++;
    if (run_done_cyc != run_t0 + 2) begin
      errors++;
      $display("FAIL elen0_latency: done at +%0d, required +2", run_done_cyc - run_t0);
    end
    checks++;
    if (run_res !== r) begin
      errors++;
      $display("FAIL elen0_result: got %h, required %h", run_res[63:0], r[63:0]);
    end
    checks++;
    if (run_first != -1 || run_busy_at_done !== 1'b1) begin
      errors++;
      $display("FAIL elen0_pulses: first_start=%0d busy_at_done=%b, required -1 and 1", run_first, run_busy_at_done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL elen0_after: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_sequence;
    logic [WIDTH-1:0] m, x, e, exp_res;
    string exp_seq;
    m = rand_mod();
    x = rand_w() % m;
    e = WIDTH'(4'b1011);
    exp_seq = "";
    for (int i = 3; i >= 0; i--) begin
      exp_seq = {exp_seq, "S"};
      if (e[i]) exp_seq = {exp_seq, "M"};
    end
    if (N_CONV == 1) exp_seq = {exp_seq, "C"};
    exp_res = golden(ONE, x, e, m, 4);
    do_run(x, ONE, e, m, 4, $urandom_range(1, 3));
    checks++;
    if (run_seq != exp_seq) begin
      errors++;
      $display("FAIL seq_order: got %s, required %s", run_seq, exp_seq);
    end
    checks++;
    if (run_res !== exp_res) begin
      errors++;
      $display("FAIL seq_result: got %h, required %h", run_res[63:0], exp_res[63:0]);
    end
    checks++;
    if (run_first != run_t0 + 1) begin
      errors++;
      $display("FAIL seq_first_start: at +%0d, required +1", run_first - run_t0);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] m, x, r, e, exp_res;
    int n, exp_ops;
    for (int it = 0; it < 6; it++) begin
      m = rand_mod();
      x = rand_w() % m;
      r = rand_w() % m;
      e = rand_w();
      n = $urandom_range(1, 24);
      exp_res = golden(r, x, e, m, n);
      exp_ops = n + popcnt(e, n) + N_CONV;
      do_run(x, r, e, m, n, $urandom_range(1, 4));
      checks++;
      if (run_res !== exp_res) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %h, required %h", it, run_res[63:0], exp_res[63:0]);
      end
      checks++;
      if (run_ns + run_nm + run_nc != exp_ops) begin
        errors++;
        $display("FAIL rand_ops[%0d]: got %0d, required %0d", it, run_ns + run_nm + run_nc, exp_ops);
      end
      checks++;
      if (run_gap != 0 || run_stab != 0) begin
        errors++;
        $display("FAIL rand_handshake[%0d]: gap_viol=%0d stab_viol=%0d, required 0 0", it, run_gap, run_stab);
      end
    end
  endtask

  task automatic test_fixed_latency;
    logic [WIDTH-1:0] m, x, e, exp_res;
    m = rand_mod();
    x = rand_w() % m;
    e = rand_w();
    exp_res = golden(ONE, x, e, m, 6);
    do_run(x, ONE, e, m, 6, 10);
    checks++;
    if (run_gap != 0) begin
      errors++;
      $display("FAIL lat10_gap: %0d starts not 1 cycle after done, required 0", run_gap);
    end
    checks++;
    if (run_stab != 0) begin
      errors++;
      $display("FAIL lat10_stable: %0d unstable wait cycles, required 0", run_stab);
    end
    checks++;
    if (run_res !== exp_res) begin
      errors++;
      $display("FAIL lat10_result: got %h, required %h", run_res[63:0], exp_res[63:0]);
    end
  endtask

  task automatic test_restart_ignored;
    logic [WIDTH-1:0] m, x, r, e, exp_res;
    m = rand_mod();
    x = rand_w() % m;
    r = rand_w() % m;
    e = rand_w();
    exp_res = golden(r, x, e, m, 8);
    fork
      do_run(x, r, e, m, 8, 3);
      begin
        repeat (6) @(posedge clk);
        #1;
        in_e = ~e; in_x = rand_w(); in_r = rand_w(); in_m = rand_mod(); in_elen = ELEN_W'(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    checks++;
    if (run_res !== exp_res) begin
      errors++;
      $display("FAIL restart_result: got %h, required %h", run_res[63:0], exp_res[63:0]);
    end
    checks++;
    if (run_ns != 8 || run_nm != popcnt(e, 8)) begin
      errors++;
      $display("FAIL restart_ops: sqr=%0d mul=%0d, required 8 %0d", run_ns, run_nm, popcnt(e, 8));
    end
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] m, x, exp_res;
    bit found, bad, saw_late;
    m = rand_mod();
    x = rand_w() % m;
    @(posedge clk); #1;
    resp_lat = 8;
    run_t0 = cyc;
    in_x = x; in_r = ONE; in_e = '1; in_m = m; in_elen = ELEN_W'(8); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_pend && cur_cls == "M") begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_reach_mul: MUL wait not reached, required within 200 cycles");
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mult_start !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rstmid_state: busy=%b done=%b mult_start=%b result=%h, required 0 0 0 0",
               busy, done, mult_start, result[63:0]);
    end
    bad = 0;
    saw_late = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mult_done) saw_late = 1;
      if (busy !== 1'b0 || done !== 1'b0 || mult_start !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || !saw_late || resp_pend) begin
      errors++;
      $display("FAIL rstmid_late_done: disturbed=%b late_done_seen=%b pending=%b, required 0 1 0",
               bad, saw_late, resp_pend);
    end
    exp_res = golden(ONE, x, WIDTH'(5'b10110), m, 5);
    do_run(x, ONE, WIDTH'(5'b10110), m, 5, 2);
    checks++;
    if (run_res !== exp_res || run_gap != 0) begin
      errors++;
      $display("FAIL rstmid_rerun: got %h gap_viol=%0d, required %h 0", run_res[63:0], run_gap, exp_res[63:0]);
    end
  endtask

  task automatic test_long;
    logic [WIDTH-1:0] m, x, r, exp_res;
    m = rand_mod();
    x = rand_w() % m;
    r = rand_w() % m;
    exp_res = golden(r, x, '1, m, 1100);
    do_run(x, r, '1, m, 1100, 1);
    checks++;
    if (run_ns != 1024 || run_nm != 1024 || run_nc != N_CONV) begin
      errors++;
      $display("FAIL long_ops: sqr=%0d mul=%0d conv=%0d, required 1024 1024 %0d", run_ns, run_nm, run_nc, N_CONV);
    end
    checks++;
    if (run_res !== exp_res) begin
      errors++;
      $display("FAIL long_result: got %h, required %h", run_res[63:0], exp_res[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_elen_zero();
    test_sequence();
    test_random();
    test_fixed_latency();
    test_restart_ignored();
    test_reset_mid();
    test_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mont_exp_sequencer.md
MONT_EXP_SEQUENCER -- requirements
Module: mont_exp_sequencer

Interface
REQ-001 Parameter: WIDTH, 1024, operand/modulus/exponent width in bits.
REQ-002 Parameter: ELEN_W, 11, width of exponent-length input.
REQ-003 Ports: clk input 1 system clock; resetn input 1 reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 in_x  input  WIDTH  base, already in Montgomery domain (x*R mod M).
REQ-006 in_r  input  WIDTH  Montgomery one (R mod M); accumulator initial value.
REQ-007 in_e  input  WIDTH  exponent; bit i weight 2^i.
REQ-008 in_elen  input  ELEN_W  number of exponent bits to process, MSB-first from bit in_elen-1.
REQ-009 in_m  input  WIDTH  modulus.
REQ-010 mult_start  output  1  one-cycle start pulse to Montgomery multiplier.
REQ-011 mult_a, mult_b, mult_m  output  WIDTH each  multiplier operands.
REQ-012 mult_result  input  WIDTH  multiplier product; valid only while mult_done=1.
REQ-013 mult_done  input  1  one-cycle multiplier completion pulse.
REQ-014 result  output  WIDTH  exponentiation result.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 busy  output  1  high from cycle after accepted start until cycle done is asserted, inclusive.

Function
REQ-017 Algorithm: A=in_r; for i=elen-1 downto 0: A=Mont(A,A); if e[i]: A=Mont(A,x); result=A.
REQ-018 States: IDLE, SQR, MUL, CONV, FIN; SQR/MUL/CONV each issue one multiply then wait for mult_done.
REQ-019 IDLE: on start, latch in_x, in_e, in_m, clamped elen into internal registers, load A=in_r, bit index=elen-1; go to SQR, or FIN if elen=0.
REQ-020 in_elen greater than WIDTH is clamped to WIDTH.
REQ-021 mult_start asserted exactly one cycle, in the first cycle of each SQR/MUL/CONV visit; first pulse one cycle after accepted start.
REQ-022 mult_a/mult_b/mult_m driven from internal registers, held stable from mult_start until mult_done of that operation.
REQ-023 SQR: mult_a=mult_b=A; on mult_done capture A<=mult_result; next MUL if e[idx]=1, else decrement-or-exit.
REQ-024 MUL: mult_a=A, mult_b=latched x; on mult_done capture A; then decrement-or-exit.
REQ-025 Decrement-or-exit: idx>0 -> idx-1, SQR; idx=0 -> CONV (macro defined) or FIN.
REQ-026 Next mult_start occurs exactly one cycle after the mult_done that completed the previous operation.
REQ-027 FIN: done=1 one cycle, result<=A registered, return to IDLE.
REQ-028 result holds value from last completion until next done or reset.
REQ-029 start while not IDLE ignored; mult_done while not waiting ignored.
REQ-030 in_* changes after acceptance have no effect on the running operation.

Reset
REQ-031 resetn low at a clock edge: state IDLE, mult_start=0, done=0, busy=0, result=0, A/index/latched operands=0.
REQ-032 Reset mid-operation aborts; a multiplier done arriving after reset is ignored; a new start afterwards runs normally.

Configuration
REQ-033 Macro MONT_EXP_FINAL_CONV_EN defined: after loop, CONV performs A=Mont(A,1) (mult_b=1) to leave Montgomery domain, then FIN.
REQ-034 Macro undefined: CONV state absent; loop exits directly to FIN; result remains in Montgomery domain.

Verification
REQ-035 elen=0, in_r=5, start at cycle t -> done=1 at t+2, result=5, mult_start never asserted.
REQ-036 e=0b1011, elen=4, behavioural multiplier model -> pulse sequence S,M,S,S,M,S,M (7 pulses); with macro one extra pulse with mult_b=1; result equals golden model.
REQ-037 Stub multiplier with fixed latency 10 cycles -> each mult_start exactly 1 cycle after previous mult_done; operands stable throughout each wait.
REQ-038 start reasserted mid-run with different in_e -> ignored; pulse count and result match original request.
REQ-039 resetn low for one cycle during MUL -> next cycle busy=0, done=0, mult_start=0, result=0; late mult_done ignored; following start completes correctly.
REQ-040 elen=1100, e=all ones -> exactly 1024 squares and 1024 multiplies before done.
